gray_conv_pipe: RTL and testbench

Parametrised, pipelined binary/Gray code converter with valid/ready streaming on both sides.
- Mode is selected per beat: binary-to-Gray or Gray-to-binary.
- Gray-to-binary is a full prefix-XOR, so its long chain is split across STAGES register stages to close timing at wide WIDTH.
- Sits in CDC pointer paths, async FIFO wrappers and encoder datapaths, replacing combinational converters wherever WIDTH or timing demands pipelining.

---
 rtl/gray_conv_pkg.sv | 22 ++
 rtl/gray_conv_stage.sv | 53 +++++
 rtl/gray_conv_pipe.sv | 104 ++++++++++
 tb/tb_gray_conv_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_conv_pkg.sv
// Shared types and chunk bit-range math for the pipelined binary/Gray converter.
// The range helpers are used by the RTL generate loop and by the bench.
package gray_conv_pkg;

   typedef enum logic {MODE_B2G = 1'b0, MODE_G2B = 1'b1} conv_mode_e;

   function automatic int chunk_size(int width, int stages);
      return (width + stages - 1) / stages;
   endfunction

   // Highest bit resolved by stage k; negative means the stage has an empty chunk.
   function automatic int chunk_hi(int width, int stages, int k);
      return width - 1 - k * chunk_size(width, stages);
   endfunction

   function automatic int chunk_lo(int width, int stages, int k);
      int lo;
      lo = width - (k + 1) * chunk_size(width, stages);
      return (lo < 0) ? 0 : lo;
   endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// One pipeline register stage: handshake state plus resolution of its Gray-to-binary chunk.
// Stage 0 (FIRST) also performs the whole binary-to-Gray conversion.
module gray_conv_stage
   import gray_conv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LO    = 0,
   parameter int HI    = 31,
   parameter bit FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             clr,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             mode
);

   logic [WIDTH-1:0] res;

   // Bits above HI are already binary, so each chunk bit folds in its upper neighbour.
   always_comb begin
      res = in_data;
      if (in_mode == MODE_B2G) begin
         if (FIRST) res = in_data ^ (in_data >> 1);
      end else begin
         for (int i = WIDTH - 2; i >= 0; i--) begin
            if (i >= LO && i <= HI) res[i] = in_data[i] ^ res[i+1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         valid <= 1'b0;
         data  <= '0;
         mode  <= 1'b0;
      end else begin
         if (clr)        valid <= 1'b0;
         else if (load)  valid <= 1'b1;
         else if (drain) valid <= 1'b0;
         if (load && !clr) begin
            data <= res;
            mode <= in_mode;
         end
      end
   end

endmodule

// File: rtl/gray_conv_pipe.sv
// Pipelined binary<->Gray converter with valid/ready on both sides and per-beat mode.
// Holds the combinational ready chain, flush handling and the stage array.
module gray_conv_pipe
   import gray_conv_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_mode,
   output logic             busy
);

   logic [STAGES-1:0]            v;
   logic [STAGES-1:0]            adv;
   logic [STAGES-1:0]            load;
   logic [STAGES-1:0]            m;
   logic [STAGES-1:0][WIDTH-1:0] d;

   // A stage may move on when its successor is empty or moving on in the same cycle.
   always_comb begin
      adv[STAGES-1] = v[STAGES-1] & out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         adv[k] = v[k] & (~v[k+1] | adv[k+1]);
      end
   end

   assign in_ready = ~flush & (~v[0] | adv[0]);

   always_comb begin
      load[0] = in_valid & in_ready;
      for (int k = 1; k < STAGES; k++) begin
         load[k] = adv[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = chunk_lo(WIDTH, STAGES, k);
      localparam int HI = chunk_hi(WIDTH, STAGES, k);
      logic [WIDTH-1:0] sd;
      logic             sm;
      if (k == 0) begin : g_src_in
         assign sd = in_data;
         assign sm = in_mode;
      end else begin : g_src_prev
         assign sd = d[k-1];
         assign sm = m[k-1];
      end
      gray_conv_stage #(
         .WIDTH (WIDTH),
         .LO    (LO),
         .HI    (HI),
         .FIRST (k == 0)
      ) u_stage (
         .clk     (clk),
         .nrst    (nrst),
         .clr     (flush),
         .load    (load[k]),
         .drain   (adv[k]),
         .in_data (sd),
         .in_mode (sm),
         .valid   (v[k]),
         .data    (d[k]),
         .mode    (m[k])
      );
   end

   assign out_valid = v[STAGES-1];
   assign out_data  = d[STAGES-1];
   assign out_mode  = m[STAGES-1];
   assign busy      = |v;

   // Source must hold an offered beat stable until it is taken.
   logic             pend;
   logic [WIDTH-1:0] pend_data;
   logic             pend_mode;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         pend      <= 1'b0;
         pend_data <= '0;
         pend_mode <= 1'b0;
      end else begin
         pend      <= in_valid & ~in_ready & ~flush;
         pend_data <= in_data;
         pend_mode <= in_mode;
      end
   end

   always_ff @(posedge clk) begin
      if (nrst && !flush && pend)
         assert (in_valid && in_data == pend_data && in_mode == pend_mode);
   end

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Bench: four converters (STAGES 4,1,3,8, WIDTH 8) on shared stimulus, each scored
// against a queue model using plain prefix-XOR arithmetic and exact latency.
module tb_gray_conv_pipe;
   import gray_conv_pkg::*;

   localparam int W = 8;
   localparam int N = 4;

   function automatic int stages_of(int g);
      case (g)
         0:       return 4;
         1:       return 1;
         2:       return 3;
         default: return 8;
      endcase
   endfunction

   logic                clk = 1'b0;
   logic                nrst = 1'b0;
   logic                flush = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_mode = 1'b0;
   logic [W-1:0]        in_data = '0;
   logic [N-1:0]        out_ready = '1;
   logic [N-1:0]        ir, ov, om, bsy;
   logic [N-1:0][W-1:0] od;
   int                  n_cmp = 0;
   int                  n_err = 0;
   bit                  lat_chk = 1'b1;
   int                  pend [N];

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         m;
      int           acc;
   } beat_t;

   function automatic logic [W-1:0] b2g(input logic [W-1:0] x);
      return x ^ (x >> 1);
   endfunction

   function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
      logic [W-1:0] b;
      for (int i = 0; i < W; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   function automatic logic [W-1:0] conv(input logic [W-1:0] x, input logic m);
      return m ? g2b(x) : b2g(x);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int S = stages_of(g);
      beat_t        q[$];
      int           ecnt = 0;
      bit           stall = 1'b0;
      logic [W-1:0] sd;
      logic         sm;

      gray_conv_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
         .clk       (clk),
         .nrst      (nrst),
         .flush     (flush),
         .in_valid  (in_valid),
         .in_ready  (ir[g]),
         .in_data   (in_data),
         .in_mode   (in_mode),
         .out_valid (ov[g]),
         .out_ready (out_ready[g]),
         .out_data  (od[g]),
         .out_mode  (om[g]),
         .busy      (bsy[g])
      );

      always @(posedge clk) begin
         ecnt++;
         stall = nrst && !flush && ov[g] && !out_ready[g];
         sd = od[g];
         sm = om[g];
         if (!nrst || flush) begin
            q.delete();
         end else begin
            if (ov[g] && out_ready[g] && q.size() > 0) void'(q.pop_front());
            if (in_valid && ir[g]) q.push_back('{in_data, in_mode, ecnt});
         end
         pend[g] = q.size();
      end

      always @(negedge clk) begin
         if (nrst) begin
            if (ov[g]) begin
               if (q.size() == 0) begin
                  check("spurious out_valid", 32'(ov[g]), 32'(0));
               end else begin
                  check("out_data", 32'(od[g]), 32'(conv(q[0].d, q[0].m)));
                  check("out_mode", 32'(om[g]), 32'(q[0].m));
               end
            end
            if (stall) begin
               check("stall data stable", 32'(od[g]), 32'(sd));
               check("stall mode stable", 32'(om[g]), 32'(sm));
            end
            if (g != 0 || lat_chk)
               check("latency valid", 32'(ov[g]),
                     32'(q.size() > 0 && q[0].acc + S - 1 == ecnt));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Single beat on an idle pipe; measures negedges from the capture edge to out_valid.
   task automatic single(input logic [W-1:0] d, input logic m, input logic [W-1:0] exp,
                         input string nm);
      int k;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      tick();
      in_valid = 1'b0;
      k = 1;
      while (!ov[0] && k < 50) begin
         @(negedge clk);
         k++;
      end
      check({nm, " data"}, 32'(od[0]), 32'(exp));
      check({nm, " mode"}, 32'(om[0]), 32'(m));
      check({nm, " latency"}, 32'(k), 32'(4));
      repeat (10) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string nm);
      for (int g = 0; g < N; g++) begin
         check({nm, " out_valid"}, 32'(ov[g]), 32'(0));
         check({nm, " busy"}, 32'(bsy[g]), 32'(0));
         check({nm, " out_data"}, 32'(od[g]), 32'(0));
         check({nm, " out_mode"}, 32'(om[g]), 32'(0));
      end
   endtask

   initial begin
      logic [W-1:0] bd [4];
      logic         bm [4];
      logic [W-1:0] be [4];
      bit           acc;
      int           tries;

      repeat (3) @(negedge clk);
      nrst = 1'b1;
      #1;
      check_reset_vals("reset");
      for (int g = 0; g < N; g++) check("reset in_ready", 32'(ir[g]), 32'(1));
      @(negedge clk);

      single(8'h2D, 1'b0, 8'h3B, "b2g 2D");
      single(8'h3B, 1'b1, 8'h2D, "g2b 3B");
      single(8'h80, 1'b1, 8'hFF, "g2b 80");

      bd = '{8'h3B, 8'h2D, 8'h80, 8'h2D};
      bm = '{1'b1, 1'b0, 1'b1, 1'b0};
      be = '{8'h2D, 8'h3B, 8'hFF, 8'h3B};
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = bd[i];
         in_mode  = bm[i];
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("b2b valid", 32'(ov[0]), 32'(1));
         check("b2b data", 32'(od[0]), 32'(be[i]));
         @(negedge clk);
      end
      repeat (8) @(negedge clk);

      // Every word through bin->gray, then the Gray images back through gray->bin.
      for (int w = 0; w < 256; w++) begin
         in_valid = 1'b1;
         in_data  = W'(w);
         in_mode  = 1'b0;
         tick();
      end
      for (int w = 0; w < 256; w++) begin
         in_valid = 1'b1;
         in_data  = b2g(W'(w));
         in_mode  = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      repeat (12) @(negedge clk);

      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = W'(8'hA1 + i);
         in_mode  = 1'b0;
         tick();
      end
      flush    = 1'b1;
      in_data  = 8'h55;
      #1;
      check("flush in_ready", 32'(ir[0]), 32'(0));
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      for (int g = 0; g < N; g++) begin
         check("flush busy", 32'(bsy[g]), 32'(0));
         check("flush out_valid", 32'(ov[g]), 32'(0));
      end
      single(8'h01, 1'b0, 8'h01, "post-flush");

      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = W'($urandom);
         in_mode  = 1'($urandom);
         tick();
      end
      in_valid = 1'b0;
      nrst     = 1'b0;
      tick();
      check_reset_vals("mid reset");
      tick();
      nrst = 1'b1;
      #1;
      for (int g = 0; g < N; g++) check("post-reset in_ready", 32'(ir[g]), 32'(1));
      @(negedge clk);
      single(8'hC4, 1'b1, 8'h87, "post-reset");

      lat_chk = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(3) == 0) begin
            in_valid     = 1'b0;
            out_ready[0] = 1'($urandom);
            tick();
         end
         in_valid = 1'b1;
         in_data  = W'($urandom);
         in_mode  = 1'($urandom);
         tries    = 0;
         acc      = 1'b0;
         while (!acc && tries < 100) begin
            out_ready[0] = 1'($urandom);
            #1;
            acc = ir[0];
            tick();
            tries++;
         end
         if (!acc) check("random accept timeout", 32'(acc), 32'(1));
      end
      in_valid     = 1'b0;
      out_ready[0] = 1'b1;
      tries = 0;
      while (bsy != '0 && tries < 100) begin
         @(negedge clk);
         tries++;
      end
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
         check("drain busy", 32'(bsy[g]), 32'(0));
         check("drain no loss", 32'(pend[g]), 32'(0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
